// File: rtl/sram_ctrl_pkg.sv
// Shared types and instance configurations for
// the 1RW SRAM initiator.
package sram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int TAG_ABITS  = 6;
  localparam int TAG_DBITS  = 80;
  localparam int TAG_MASKW  = 4;

  localparam int DATA_ABITS = 9;
  localparam int DATA_DBITS = 64;
  localparam int DATA_MASKW = 1;

endpackage

// File: rtl/sram_resp_skid.sv
// One-entry read response hold buffer: passes SRAM
// rdata through, then freezes it while stalled.
module sram_resp_skid #(
  parameter int DBITS = 80
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_load,
  input  logic [DBITS-1:0] i_rdata,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [DBITS-1:0] o_rdata
);

  logic             vld_q;
  logic             held_q;
  logic [DBITS-1:0] buf_q;

  // Valid/held flags; a new load always restarts pass-through.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      vld_q  <= 1'b0;
      held_q <= 1'b0;
    end else begin
      vld_q  <= i_load | (vld_q & ~i_ready);
      held_q <= ~i_load & vld_q & ~i_ready;
    end
  end

  // Capture rdata at the end of the first stalled cycle.
  always_ff @(posedge i_clk) begin
    if (vld_q && !held_q) begin
      buf_q <= i_rdata;
    end
  end

  assign o_valid = vld_q;
  assign o_rdata = held_q ? buf_q : i_rdata;

endmodule

// File: rtl/sram_rw_initiator.sv
// Request/response front end for a 1RW SRAM macro,
// with optional zero-fill sweep after reset.
module sram_rw_initiator
  import sram_ctrl_pkg::*;
#(
  parameter int ABITS    = TAG_ABITS,
  parameter int DBITS    = TAG_DBITS,
  parameter int MASKW    = TAG_MASKW,
  parameter bit INIT_ENA = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_write,
  input  logic [ABITS-1:0] i_req_addr,
  input  logic [DBITS-1:0] i_req_wdata,
  input  logic [MASKW-1:0] i_req_wmask,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [DBITS-1:0] o_resp_rdata,
  output logic             o_init_done,
  output logic [ABITS-1:0] o_ram_addr,
  output logic             o_ram_en,
  output logic             o_ram_wmode,
  output logic [MASKW-1:0] o_ram_wmask,
  output logic [DBITS-1:0] o_ram_wdata,
  input  logic [DBITS-1:0] i_ram_rdata
);

  localparam int DEPTH = 2 ** ABITS;
  localparam logic [ABITS:0] CNT_LAST =
    (ABITS+1)'(DEPTH - 1);
  localparam state_e RST_STATE =
    INIT_ENA ? INIT : RUN;

  state_e         state_q;
  state_e         state_d;
  logic [ABITS:0] cnt_q;
  logic [ABITS:0] cnt_d;
  logic           skid_valid;
  logic           rd_load;
  logic           accept;

  // State and fill counter register.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and SRAM port drive; all strobes gated by reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_ram_en    = 1'b0;
    o_ram_wmode = 1'b0;
    o_ram_wmask = '0;
    o_ram_wdata = '0;
    o_ram_addr  = '0;
    o_req_ready = 1'b0;
    o_init_done = 1'b0;
    accept      = 1'b0;
    rd_load     = 1'b0;
    unique case (state_q)
      INIT: begin
        o_ram_en    = i_nrst;
        o_ram_wmode = 1'b1;
        o_ram_wmask = '1;
        o_ram_addr  = cnt_q[ABITS-1:0];
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        o_init_done = i_nrst;
        o_req_ready = i_nrst &
          (~skid_valid | i_resp_ready);
        accept      = i_req_valid & o_req_ready;
        o_ram_en    = accept;
        o_ram_addr  = i_req_addr;
        o_ram_wmode = i_req_write;
        o_ram_wmask = i_req_write ? i_req_wmask : '0;
        o_ram_wdata = i_req_wdata;
        rd_load     = accept & ~i_req_write;
      end
    endcase
  end

  sram_resp_skid #(
    .DBITS(DBITS)
  ) u_skid (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_load (rd_load),
    .i_rdata(i_ram_rdata),
    .o_valid(skid_valid),
    .i_ready(i_resp_ready),
    .o_rdata(o_resp_rdata)
  );

  assign o_resp_valid = i_nrst & skid_valid;

endmodule
